// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: the core pushes bytes, a 4-state drain FSM strobes them out one at a time.
// Optional sticky overflow flag (ports ovf_clr/overflow) when UART_FIFO_OVF_FLAG_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_from_FPGA,
    input  logic              rst_from_FPGA,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              uart_busy,
    output logic              uart_write_en,
    output logic [7:0]        uart_data
`ifdef UART_FIFO_OVF_FLAG_EN
    ,
    input  logic              ovf_clr,
    output logic              overflow
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              uart_we_q, uart_we_d;
    logic [7:0]        uart_data_q;
    state_t            state_q, state_d;
    logic              push;
    logic              pop;

    // Both decisions use registered flags, so a full FIFO rejects a push even when a pop happens that cycle.
    assign push = wr_en && !full_q;
    assign pop  = (state_q == S_IDLE) && !empty_q && !uart_busy;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
        full_d  = (count_d == (ADDR_W+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_comb begin
        state_d   = state_q;
        uart_we_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    uart_we_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_WAIT_HI;
            // uart_tx may take a few cycles to raise busy after the strobe
            S_WAIT_HI: if (uart_busy)  state_d = S_WAIT_LO;
            S_WAIT_LO: if (!uart_busy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Storage is not reset so it can map onto block RAM.
    always_ff @(posedge clk_from_FPGA) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            uart_we_q   <= 1'b0;
            uart_data_q <= 8'h00;
            state_q     <= S_IDLE;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            uart_we_q <= uart_we_d;
            state_q   <= state_d;
            if (pop) begin
                uart_data_q <= mem_q[rptr_q];
            end
        end
    end

    assign full          = full_q;
    assign empty         = empty_q;
    assign count         = count_q;
    assign uart_write_en = uart_we_q;
    assign uart_data     = uart_data_q;

`ifdef UART_FIFO_OVF_FLAG_EN
    logic overflow_q, overflow_d;

    // A rejected push in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx busy model.
// Exercises the overflow flag too when UART_FIFO_OVF_FLAG_EN is defined.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b1;
    logic              wr_en   = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              uart_busy;
    logic              uart_write_en;
    logic [7:0]        uart_data;
`ifdef UART_FIFO_OVF_FLAG_EN
    logic              ovf_clr = 1'b0;
    logic              overflow;
`endif

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_from_FPGA (clk),
        .rst_from_FPGA (rst_n),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .uart_busy     (uart_busy),
        .uart_write_en (uart_write_en),
        .uart_data     (uart_data)
`ifdef UART_FIFO_OVF_FLAG_EN
        ,
        .ovf_clr       (ovf_clr),
        .overflow      (overflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: occupancy, scoreboard and uart_tx busy behaviour.
    int         m_cnt      = 0;
    int         acc_pend   = 0;
    int         acc_total  = 0;
    int         str_cnt    = 0;
    int         fall_cnt   = 0;
    int         pending    = 0;
    int         hi_cnt     = 0;
    int         busy_delay = 1;
    logic       busy_m     = 1'b0;
    logic       hold_busy  = 1'b0;
    logic [7:0] held       = 8'h00;
    logic [7:0] sb[$];

    assign uart_busy = busy_m | hold_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt    = 0;
            acc_pend = 0;
            pending  = 0;
            hi_cnt   = 0;
            busy_m   = 1'b0;
            sb.delete();
        end else begin
            m_cnt    = m_cnt + acc_pend - (uart_write_en ? 1 : 0);
            acc_pend = 0;
            chk("count", 32'(count), 32'(m_cnt));
            chk("empty", 32'(empty), 32'(m_cnt == 0));
            chk("full",  32'(full),  32'(m_cnt == DEPTH));
            if (uart_write_en) begin
                chk("strobe_while_busy", 32'(busy_m || pending != 0), 32'd0);
                str_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("tx_data", 32'(uart_data), 32'(sb.pop_front()));
                end
                $display("tx byte %02h at %0t", uart_data, $time);
                held    = uart_data;
                pending = busy_delay;
            end else if (pending != 0) begin
                pending--;
                if (pending == 0) begin
                    busy_m = 1'b1;
                    hi_cnt = 10;
                end
            end else if (busy_m) begin
                hi_cnt--;
                if (hi_cnt == 0) begin
                    busy_m = 1'b0;
                    chk("data_hold", 32'(uart_data), 32'(held));
                    fall_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called just after a falling edge; holds wr_en for one rising edge.
    task automatic drive_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (m_cnt < DEPTH) begin
            sb.push_back(b);
            acc_pend = 1;
            acc_total++;
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (!(m_cnt == 0 && !busy_m && pending == 0 && !uart_write_en) && n < max) begin
            step();
            n++;
        end
        if (n >= max) chk("idle_timeout", 32'd1, 32'd0);
        step();
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int f0;
        int n;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we",    32'(uart_write_en), 32'd0);
        chk("rst_data",  32'(uart_data), 32'h00);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single byte: strobe two cycles after the push
        s0 = str_cnt;
        drive_byte(8'h41);
        chk("lat_early", 32'(uart_write_en), 32'd0);
        step();
        chk("lat_strobe", 32'(uart_write_en), 32'd1);
        chk("lat_data",   32'(uart_data), 32'h41);
        step();
        chk("strobe_width", 32'(uart_write_en), 32'd0);
        wait_idle(100);
        chk("single_count",   32'(count), 32'd0);
        chk("single_strobes", 32'(str_cnt - s0), 32'd1);

        // Burst of 16 with the UART held busy, then a rejected 17th byte
        hold_busy = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) drive_byte(8'(i));
        chk("burst_full",  32'(full),  32'd1);
        chk("burst_count", 32'(count), 32'd16);
        drive_byte(8'hEE);
        chk("ovf_count", 32'(count), 32'd16);
`ifdef UART_FIFO_OVF_FLAG_EN
        chk("ovf_set", 32'(overflow), 32'd1);
        step();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        drive_byte(8'hEE);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
`endif
        hold_busy = 1'b0;
        wait_idle(1000);
        chk("burst_drained", 32'(sb.size()), 32'd0);

        // Push and pop on the same edge at count=3, for 20 pointer wraps
        hold_busy = 1'b1;
        step();
        drive_byte(8'h80);
        drive_byte(8'h81);
        drive_byte(8'h82);
        hold_busy = 1'b0;
        drive_byte(8'h83);
        chk("pp_count", 32'(count), 32'd3);
        for (int k = 0; k < 20 * DEPTH - 1; k++) begin
            f0 = fall_cnt;
            n  = 0;
            while (fall_cnt == f0 && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) chk("pp_timeout", 32'd1, 32'd0);
            step();
            drive_byte(8'(k * 7 + 5));
            chk("pp_count", 32'(count), 32'd3);
        end
        wait_idle(200);
        chk("pp_drained", 32'(sb.size()), 32'd0);

        // Slow busy: busy rises 3 cycles after the strobe
        busy_delay = 3;
        hold_busy  = 1'b1;
        step();
        drive_byte(8'hA5);
        drive_byte(8'h5A);
        s0 = str_cnt;
        hold_busy = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("slow_no_strobe", 32'(uart_write_en), 32'd0);
        end
        chk("slow_one_strobe", 32'(str_cnt - s0), 32'd1);
        chk("slow_count",      32'(count), 32'd1);
        wait_idle(200);
        busy_delay = 1;

        // Reset while a frame is in flight
        drive_byte(8'h33);
        drive_byte(8'h44);
        n = 0;
        while (!uart_write_en && n < 10) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(uart_write_en), 32'd0);
        chk("mid_rst_data",  32'(uart_data), 32'h00);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full",  32'(full),  32'd0);
        sb.delete();
        m_cnt     = 0;
        acc_pend  = 0;
        pending   = 0;
        busy_m    = 1'b0;
        acc_total = str_cnt;
        step();
        step();
        rst_n = 1'b1;
        step();
        drive_byte(8'h5C);
        wait_idle(100);

        chk("all_sent", 32'(str_cnt), 32'(acc_total));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
